fir_dac: RTL and testbench

//  Self-contained FIR demonstrator driving a dual-channel 8-bit DAC.
//  - Builds a test signal from a low tone plus a key-selected high tone.
//  - Channel A outputs the raw signal; channel B outputs it after a 16-tap symmetric low-pass FIR.
//  - Top-level block between board keys/clock and the external DAC pins.

---
 rtl/fir_dac.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fir_dac.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_dac.sv
// fir_dac: two-tone test signal generator feeding a 16-tap symmetric low-pass FIR, driving a
// dual-channel 8-bit DAC. Define KEY_SYNC_EN to pass key through a 2-flop synchronizer first.
module fir_dac #(
    parameter int unsigned SAMPLE_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] key,
    output logic       dac_mode,
    output logic       dac_clka,
    output logic [7:0] dac_da,
    output logic       dac_wra,
    output logic       dac_sleep,
    output logic       dac_clkb,
    output logic [7:0] dac_db,
    output logic       dac_wrb
);

    localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SAMPLE_DIV - 1);

    // Quarter-wave table: round(127 * sin(2*pi*i/256)) for i = 0..63.
    function automatic logic [6:0] quarter(input logic [5:0] idx);
        logic [6:0] q;
        case (idx)
            6'd0:  q = 7'd0;
            6'd1:  q = 7'd3;
            6'd2:  q = 7'd6;
            6'd3:  q = 7'd9;
            6'd4:  q = 7'd12;
            6'd5:  q = 7'd16;
            6'd6:  q = 7'd19;
            6'd7:  q = 7'd22;
            6'd8:  q = 7'd25;
            6'd9:  q = 7'd28;
            6'd10: q = 7'd31;
            6'd11: q = 7'd34;
            6'd12: q = 7'd37;
            6'd13: q = 7'd40;
            6'd14: q = 7'd43;
            6'd15: q = 7'd46;
            6'd16: q = 7'd49;
            6'd17: q = 7'd51;
            6'd18: q = 7'd54;
            6'd19: q = 7'd57;
            6'd20: q = 7'd60;
            6'd21: q = 7'd63;
            6'd22: q = 7'd65;
            6'd23: q = 7'd68;
            6'd24: q = 7'd71;
            6'd25: q = 7'd73;
            6'd26: q = 7'd76;
            6'd27: q = 7'd78;
            6'd28: q = 7'd81;
            6'd29: q = 7'd83;
            6'd30: q = 7'd85;
            6'd31: q = 7'd88;
            6'd32: q = 7'd90;
            6'd33: q = 7'd92;
            6'd34: q = 7'd94;
            6'd35: q = 7'd96;
            6'd36: q = 7'd98;
            6'd37: q = 7'd100;
            6'd38: q = 7'd102;
            6'd39: q = 7'd104;
            6'd40: q = 7'd106;
            6'd41: q = 7'd107;
            6'd42: q = 7'd109;
            6'd43: q = 7'd111;
            6'd44: q = 7'd112;
            6'd45: q = 7'd113;
            6'd46: q = 7'd115;
            6'd47: q = 7'd116;
            6'd48: q = 7'd117;
            6'd49: q = 7'd118;
            6'd50: q = 7'd120;
            6'd51: q = 7'd121;
            6'd52: q = 7'd122;
            6'd53: q = 7'd122;
            6'd54: q = 7'd123;
            6'd55: q = 7'd124;
            6'd56: q = 7'd125;
            6'd57: q = 7'd125;
            6'd58: q = 7'd126;
            6'd59: q = 7'd126;
            6'd60: q = 7'd126;
            6'd61: q = 7'd127;
            6'd62: q = 7'd127;
            6'd63: q = 7'd127;
            default: q = 7'd0;
        endcase
        return q;
    endfunction

    // Full-wave sine from the quarter table: mirror in the odd quadrants, negate in the upper half.
    // The quadrant peak (index 64 / 192) is not in the table and is handled explicitly.
    function automatic logic signed [7:0] sine(input logic [7:0] p);
        logic [5:0]        idx;
        logic [6:0]        mag;
        logic signed [7:0] smag;
        idx = p[6] ? (6'd0 - p[5:0]) : p[5:0];
        if (p[6] && (p[5:0] == 6'd0)) begin
            mag = 7'd127;
        end else begin
            mag = quarter(idx);
        end
        smag = {1'b0, mag};
        return p[7] ? -smag : smag;
    endfunction

    // Symmetric coefficients c[0..7]; c[15-i] = c[i], sum of all 16 is 128.
    function automatic logic signed [15:0] coef(input int unsigned idx);
        logic signed [15:0] c;
        case (idx)
            0:       c = 16'sd1;
            1:       c = 16'sd2;
            2:       c = 16'sd3;
            3:       c = 16'sd5;
            4:       c = 16'sd8;
            5:       c = 16'sd11;
            6:       c = 16'sd14;
            7:       c = 16'sd20;
            default: c = 16'sd0;
        endcase
        return c;
    endfunction

    // Sample-rate divider
    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic            tick;

    always_comb begin
        tick      = (div_cnt_q == CntMax);
        div_cnt_d = tick ? '0 : div_cnt_q + CntW'(1);
    end

    // rst_n is active-high despite its name: rst_n = 1 holds the block in reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // High-tone step selection
    logic [2:0] key_use;

`ifdef KEY_SYNC_EN
    logic [2:0] key_s1_q, key_s2_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            key_s1_q <= '0;
            key_s2_q <= '0;
        end else begin
            key_s1_q <= key;
            key_s2_q <= key_s1_q;
        end
    end

    assign key_use = key_s2_q;
`else
    assign key_use = key;
`endif

    logic [7:0] hi_step;
    assign hi_step = 8'd32 + {2'b00, key_use, 3'b000};

    // Tone generation and input sample
    logic [7:0]        phase_lo_q, phase_hi_q;
    logic signed [7:0] sin_lo, sin_hi, x_new;
    logic signed [8:0] x_sum, x_half;

    always_comb begin
        sin_lo = sine(phase_lo_q);
        sin_hi = sine(phase_hi_q);
        x_sum  = {sin_lo[7], sin_lo} + {sin_hi[7], sin_hi};
        x_half = x_sum >>> 1;
        x_new  = x_half[7:0];
    end

    logic signed [7:0] dly_q [16];
    logic [7:0]        dac_da_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            phase_lo_q <= '0;
            phase_hi_q <= '0;
            dac_da_q   <= 8'h80;
            for (int i = 0; i < 16; i++) begin
                dly_q[i] <= '0;
            end
        end else if (tick) begin
            phase_lo_q <= phase_lo_q + 8'd1;
            phase_hi_q <= phase_hi_q + hi_step;
            dac_da_q   <= x_new ^ 8'h80;
            dly_q[0]   <= x_new;
            for (int i = 1; i < 16; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    // FIR: pre-add symmetric taps and multiply, then sum, round and saturate.
    logic signed [8:0]  pre_sum [8];
    logic signed [15:0] prod_d  [8];
    logic signed [15:0] prod_q  [8];
    logic signed [15:0] acc;
    logic signed [16:0] acc_rnd, y_full;
    logic signed [7:0]  y_sat;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pre_sum[i] = {dly_q[i][7], dly_q[i]} + {dly_q[15-i][7], dly_q[15-i]};
            prod_d[i]  = 16'(pre_sum[i]) * coef(i);
        end
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            acc = acc + prod_q[i];
        end
        acc_rnd = 17'(acc) + 17'sd64;
        y_full  = acc_rnd >>> 7;
        if (y_full > 17'sd127) begin
            y_sat = 8'h7f;
        end else if (y_full < -17'sd128) begin
            y_sat = 8'h80;
        end else begin
            y_sat = y_full[7:0];
        end
    end

    logic [7:0] dac_db_q;

    // These stages run every clock, so dac_db trails dac_da by exactly two clocks.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            dac_db_q <= 8'h80;
            for (int i = 0; i < 8; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            dac_db_q <= y_sat ^ 8'h80;
            for (int i = 0; i < 8; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign dac_da    = dac_da_q;
    assign dac_db    = dac_db_q;
    assign dac_mode  = 1'b1;
    assign dac_sleep = 1'b0;
    assign dac_clka  = ~clk;
    assign dac_wra   = ~clk;
    assign dac_clkb  = ~clk;
    assign dac_wrb   = ~clk;

endmodule

// File: tb/tb_fir_dac.sv
// Testbench for fir_dac: two instances (SAMPLE_DIV 1 and 4) checked against a behavioural model
// built from sin(), direct 16-tap convolution and a sample-count phase model.
module tb_fir_dac;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] key = 3'd0;

    logic       dac_mode, dac_clka, dac_wra, dac_sleep, dac_clkb, dac_wrb;
    logic [7:0] dac_da, dac_db;
    logic       d4_mode, d4_clka, d4_wra, d4_sleep, d4_clkb, d4_wrb;
    logic [7:0] d4_da, d4_db;

    fir_dac #(.SAMPLE_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .key(key),
        .dac_mode(dac_mode), .dac_clka(dac_clka), .dac_da(dac_da), .dac_wra(dac_wra),
        .dac_sleep(dac_sleep), .dac_clkb(dac_clkb), .dac_db(dac_db), .dac_wrb(dac_wrb)
    );

    fir_dac #(.SAMPLE_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .key(key),
        .dac_mode(d4_mode), .dac_clka(d4_clka), .dac_da(d4_da), .dac_wra(d4_wra),
        .dac_sleep(d4_sleep), .dac_clkb(d4_clkb), .dac_db(d4_db), .dac_wrb(d4_wrb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int coef_tab[16] = '{1, 2, 3, 5, 8, 11, 14, 20, 20, 14, 11, 8, 5, 3, 2, 1};

    // Reference model state, index 0 = SAMPLE_DIV 1, index 1 = SAMPLE_DIV 4
    int m_div[2] = '{1, 4};
    int m_cnt[2], m_lo[2], m_hi[2];
    int m_hist[2][16];
    int m_yp1[2], m_yp2[2];
    int m_da[2], m_db[2];
    bit m_tick[2];
    int m_ks1, m_ks2;
    int first_da[20];

    function automatic int sine_ref(input int p);
        real v;
        v = 127.0 * $sin(2.0 * 3.141592653589793 * p / 256.0);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic int fir_ref(input int u);
        int acc, y;
        acc = 0;
        for (int j = 0; j < 16; j++) acc += coef_tab[j] * m_hist[u][j];
        y = (acc + 64) >>> 7;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return y;
    endfunction

    task automatic model_update();
        int ke, x;
`ifdef KEY_SYNC_EN
        ke = m_ks2;
`else
        ke = int'(key);
`endif
        for (int u = 0; u < 2; u++) begin
            if (rst_n) begin
                m_cnt[u] = 0; m_lo[u] = 0; m_hi[u] = 0;
                for (int j = 0; j < 16; j++) m_hist[u][j] = 0;
                m_yp1[u] = 0; m_yp2[u] = 0;
                m_da[u] = 128; m_db[u] = 128; m_tick[u] = 1'b0;
            end else begin
                m_tick[u] = (m_cnt[u] == m_div[u] - 1);
                m_cnt[u] = m_tick[u] ? 0 : m_cnt[u] + 1;
                m_db[u] = m_yp2[u] + 128;
                if (m_tick[u]) begin
                    x = (sine_ref(m_lo[u]) + sine_ref(m_hi[u])) >>> 1;
                    for (int j = 15; j > 0; j--) m_hist[u][j] = m_hist[u][j-1];
                    m_hist[u][0] = x;
                    m_da[u] = x + 128;
                    m_lo[u] = (m_lo[u] + 1) % 256;
                    m_hi[u] = (m_hi[u] + 32 + 8 * ke) % 256;
                end
                m_yp2[u] = m_yp1[u];
                m_yp1[u] = fir_ref(u);
            end
        end
        if (rst_n) begin
            m_ks1 = 0; m_ks2 = 0;
        end else begin
            m_ks2 = m_ks1; m_ks1 = int'(key);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        key = 3'd0;
        for (int i = 0; i < 10; i++) tick_clk();
        n_checks++;
        if (dac_da !== 8'h80) begin
            n_errors++; $display("FAIL reset_da: got %h want 80", dac_da);
        end
        n_checks++;
        if (dac_db !== 8'h80) begin
            n_errors++; $display("FAIL reset_db: got %h want 80", dac_db);
        end
        n_checks++;
        if (d4_da !== 8'h80 || d4_db !== 8'h80) begin
            n_errors++; $display("FAIL reset_div4: got %h/%h want 80/80", d4_da, d4_db);
        end
        n_checks++;
        if (dac_mode !== 1'b1 || dac_sleep !== 1'b0) begin
            n_errors++; $display("FAIL mode_sleep: got %b/%b want 1/0", dac_mode, dac_sleep);
        end
        n_checks++;
        if ({dac_clka, dac_wra, dac_clkb, dac_wrb} !== {4{~clk}}) begin
            n_errors++;
            $display("FAIL dac_clk_low: got %b%b%b%b want %b", dac_clka, dac_wra, dac_clkb,
                     dac_wrb, ~clk);
        end
        @(posedge clk);
        model_update();
        #1;
        n_checks++;
        if ({dac_clka, dac_wra, dac_clkb, dac_wrb} !== {4{~clk}}) begin
            n_errors++;
            $display("FAIL dac_clk_high: got %b%b%b%b want %b", dac_clka, dac_wra, dac_clkb,
                     dac_wrb, ~clk);
        end
        @(negedge clk);
    endtask

    task automatic test_first_samples();
        rst_n = 1'b0;
        key = 3'd0;
        for (int i = 0; i < 20; i++) begin
            tick_clk();
            first_da[i] = m_da[0];
            if (i == 0) begin
                n_checks++;
                if (dac_da !== 8'h80) begin
                    n_errors++; $display("FAIL first_sample: got %h want 80", dac_da);
                end
            end
            if (i == 1) begin
                n_checks++;
                if (dac_da !== 8'hAE) begin
                    n_errors++; $display("FAIL second_sample: got %h want ae", dac_da);
                end
            end
            n_checks++;
            if (dac_da !== 8'(m_da[0]) || dac_db !== 8'(m_db[0])) begin
                n_errors++;
                $display("FAIL startup[%0d]: got %h/%h want %h/%h", i, dac_da, dac_db,
                         8'(m_da[0]), 8'(m_db[0]));
            end
        end
    endtask

    task automatic test_key0_fir();
        key = 3'd0;
        for (int i = 0; i < 300; i++) begin
            tick_clk();
            n_checks++;
            if (dac_da !== 8'(m_da[0])) begin
                n_errors++; $display("FAIL key0_da[%0d]: got %h want %h", i, dac_da, 8'(m_da[0]));
            end
            n_checks++;
            if (dac_db !== 8'(m_db[0])) begin
                n_errors++; $display("FAIL key0_db[%0d]: got %h want %h", i, dac_db, 8'(m_db[0]));
            end
        end
    endtask

    task automatic test_key_sweep();
        int amp[8];
        int a;
        for (int k = 0; k < 8; k++) begin
            key = 3'(k);
            amp[k] = 0;
            for (int i = 0; i < 262 * (k + 1); i++) begin
                tick_clk();
                n_checks++;
                if (dac_da !== 8'(m_da[0]) || dac_db !== 8'(m_db[0])) begin
                    n_errors++;
                    $display("FAIL sweep_k%0d[%0d]: got %h/%h want %h/%h", k, i, dac_da, dac_db,
                             8'(m_da[0]), 8'(m_db[0]));
                end
                n_checks++;
                if (d4_da !== 8'(m_da[1]) || d4_db !== 8'(m_db[1])) begin
                    n_errors++;
                    $display("FAIL sweep_div4_k%0d[%0d]: got %h/%h want %h/%h", k, i, d4_da,
                             d4_db, 8'(m_da[1]), 8'(m_db[1]));
                end
                if (i >= 20) begin
                    a = int'(dac_db) - 128;
                    if (a < 0) a = -a;
                    if (a > amp[k]) amp[k] = a;
                end
            end
        end
        n_checks++;
        if (!(amp[7] < amp[0])) begin
            n_errors++; $display("FAIL sweep_amplitude: got k7=%0d k0=%0d want k7<k0", amp[7], amp[0]);
        end
    endtask

    task automatic test_div4();
        logic [7:0] prev;
        for (int i = 0; i < 80; i++) begin
            if (i % 7 == 0) key = 3'($urandom_range(0, 7));
            prev = d4_da;
            tick_clk();
            n_checks++;
            if (d4_da !== 8'(m_da[1]) || d4_db !== 8'(m_db[1])) begin
                n_errors++;
                $display("FAIL div4[%0d]: got %h/%h want %h/%h", i, d4_da, d4_db,
                         8'(m_da[1]), 8'(m_db[1]));
            end
            if (!m_tick[1]) begin
                n_checks++;
                if (d4_da !== prev) begin
                    n_errors++; $display("FAIL div4_hold[%0d]: got %h want %h", i, d4_da, prev);
                end
            end
        end
    endtask

    task automatic test_random_keys();
        int hold;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                key = 3'($urandom_range(0, 7));
                hold = $urandom_range(1, 20);
            end
            hold--;
            tick_clk();
            n_checks++;
            if (dac_da !== 8'(m_da[0]) || dac_db !== 8'(m_db[0])) begin
                n_errors++;
                $display("FAIL random_keys[%0d]: got %h/%h want %h/%h", i, dac_da, dac_db,
                         8'(m_da[0]), 8'(m_db[0]));
            end
            n_checks++;
            if (d4_da !== 8'(m_da[1]) || d4_db !== 8'(m_db[1])) begin
                n_errors++;
                $display("FAIL random_keys_div4[%0d]: got %h/%h want %h/%h", i, d4_da, d4_db,
                         8'(m_da[1]), 8'(m_db[1]));
            end
        end
    endtask

    task automatic test_reset_mid();
        key = 3'($urandom_range(1, 7));
        for (int i = 0; i < 37; i++) tick_clk();
        rst_n = 1'b1;
        key = 3'd0;
        tick_clk();
        n_checks++;
        if (dac_da !== 8'h80 || dac_db !== 8'h80) begin
            n_errors++; $display("FAIL mid_reset: got %h/%h want 80/80", dac_da, dac_db);
        end
        n_checks++;
        if (d4_da !== 8'h80 || d4_db !== 8'h80) begin
            n_errors++; $display("FAIL mid_reset_div4: got %h/%h want 80/80", d4_da, d4_db);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick_clk();
            n_checks++;
            if (dac_da !== 8'(first_da[i])) begin
                n_errors++;
                $display("FAIL restart[%0d]: got %h want %h", i, dac_da, 8'(first_da[i]));
            end
            n_checks++;
            if (dac_db !== 8'(m_db[0])) begin
                n_errors++; $display("FAIL restart_db[%0d]: got %h want %h", i, dac_db, 8'(m_db[0]));
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_samples();
        test_key0_fir();
        test_key_sweep();
        test_div4();
        test_random_keys();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
